// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and helpers.
// Defaults describe 640x480@60 (800x525 total).
package vga_timing_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  localparam int CW_DEF = 10;

  function automatic int calc_total(
    input int active,
    input int fp,
    input int sync,
    input int bp
  );
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus
// sync-window and active-region decode.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FP     = H_FP_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BP     = H_BP_DEF,
  parameter int CW     = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          sync_raw,
  output logic          active
);

  localparam int TOTAL = calc_total(ACTIVE, FP, SYNC, BP);

  localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACT_END = CW'(ACTIVE);
  localparam logic [CW-1:0] SYN_LO  = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYN_HI  = CW'(ACTIVE + FP + SYNC);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: hold, increment, or wrap (also recovers out-of-range).
  always_comb begin
    count_d = count_q;
    if (step) begin
      if (count_q >= LAST) count_d = '0;
      else                 count_d = count_q + CW'(1);
    end
  end

  // Counter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count    = count_q;
  assign wrap     = step && (count_q == LAST);
  assign sync_raw = (count_q >= SYN_LO) && (count_q < SYN_HI);
  assign active   = count_q < ACT_END;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (h/v counters, syncs, strobes).
// Define VGA_TIMING_OUT_REG_EN to register all outputs (1 clk lag).
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = SYNC_ACTIVE_LOW,
  parameter int CW       = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en,
  output logic [CW-1:0] h_count,
  output logic [CW-1:0] v_count,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          line_end,
  output logic          frame_end
);

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          h_wrap;
  logic          v_wrap;
  logic          h_sync_raw;
  logic          v_sync_raw;
  logic          h_act;
  logic          v_act;

  logic          hsync_d;
  logic          vsync_d;
  logic          video_on_d;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .CW     (CW)
  ) u_h (
    .clk      (clk),
    .rst_n    (rst_n),
    .step     (pix_en),
    .count    (h_cnt),
    .wrap     (h_wrap),
    .sync_raw (h_sync_raw),
    .active   (h_act)
  );

  // Vertical axis advances once per completed line.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .CW     (CW)
  ) u_v (
    .clk      (clk),
    .rst_n    (rst_n),
    .step     (h_wrap),
    .count    (v_cnt),
    .wrap     (v_wrap),
    .sync_raw (v_sync_raw),
    .active   (v_act)
  );

  assign hsync_d    = h_sync_raw ? SYNC_POL : ~SYNC_POL;
  assign vsync_d    = v_sync_raw ? SYNC_POL : ~SYNC_POL;
  assign video_on_d = h_act && v_act;

`ifdef VGA_TIMING_OUT_REG_EN

  logic [CW-1:0] h_count_q;
  logic [CW-1:0] v_count_q;
  logic          hsync_q;
  logic          vsync_q;
  logic          video_on_q;
  logic          line_end_q;
  logic          frame_end_q;

  // Single aligned output stage; every clk, not gated by pix_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_count_q   <= '0;
      v_count_q   <= '0;
      hsync_q     <= ~SYNC_POL;
      vsync_q     <= ~SYNC_POL;
      video_on_q  <= 1'b0;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      h_count_q   <= h_cnt;
      v_count_q   <= v_cnt;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      video_on_q  <= video_on_d;
      line_end_q  <= h_wrap;
      frame_end_q <= v_wrap;
    end
  end

  assign h_count   = h_count_q;
  assign v_count   = v_count_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign video_on  = video_on_q;
  assign line_end  = line_end_q;
  assign frame_end = frame_end_q;

`else

  assign h_count   = h_cnt;
  assign v_count   = v_cnt;
  assign hsync     = hsync_d;
  assign vsync     = vsync_d;
  assign video_on  = video_on_d;
  assign line_end  = h_wrap;
  assign frame_end = v_wrap;

`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: a small-timing
// instance (25x15) and a default 640x480 instance.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_OUT_REG_EN
  localparam bit REG = 1'b1;
`else
  localparam bit REG = 1'b0;
`endif

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       von;
    logic       le;
    logic       fe;
  } obs_t;

  typedef struct packed {
    obs_t s;
    obs_t d;
  } pair_t;

  logic clk = 1'b0;
  logic rst_n;
  logic pix_en;

  logic [4:0] h_s, v_s;
  logic       hs_s, vs_s, von_s, le_s, fe_s;
  logic [9:0] h_d, v_d;
  logic       hs_d, vs_d, von_d, le_d, fe_d;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (3),
    .V_ACTIVE (8),  .V_FP (2), .V_SYNC (2), .V_BP (3),
    .SYNC_POL (1'b0), .CW (5)
  ) u_small (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_en    (pix_en),
    .h_count   (h_s),
    .v_count   (v_s),
    .hsync     (hs_s),
    .vsync     (vs_s),
    .video_on  (von_s),
    .line_end  (le_s),
    .frame_end (fe_s)
  );

  vga_timing_gen u_def (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_en    (pix_en),
    .h_count   (h_d),
    .v_count   (v_d),
    .hsync     (hs_d),
    .vsync     (vs_d),
    .video_on  (von_d),
    .line_end  (le_d),
    .frame_end (fe_d)
  );

  int    compared   = 0;
  int    mismatched = 0;
  pair_t q[$];

  int    mh[2];
  int    mv[2];
  obs_t  oreg[2];
  obs_t  lastc[2];
  logic  last_pe;

  // Reference timing, k=0 small, k=1 default 640x480.
  function automatic obs_t model(input int k, input int h,
                                 input int v, input logic pe);
    int   ha, hf, hw, ht, va, vf, vw, vt;
    obs_t m;
    ha = (k == 0) ? 16 : 640;
    hf = (k == 0) ? 2  : 16;
    hw = (k == 0) ? 4  : 96;
    ht = (k == 0) ? 25 : 800;
    va = (k == 0) ? 8  : 480;
    vf = (k == 0) ? 2  : 10;
    vw = 2;
    vt = (k == 0) ? 15 : 525;
    m.h   = 10'(h);
    m.v   = 10'(v);
    m.hs  = !(h >= ha + hf && h < ha + hf + hw);
    m.vs  = !(v >= va + vf && v < va + vf + vw);
    m.von = (h < ha) && (v < va);
    m.le  = pe && (h == ht - 1);
    m.fe  = m.le && (v == vt - 1);
    return m;
  endfunction

  function automatic obs_t rstv();
    obs_t r;
    r    = '0;
    r.hs = 1'b1;
    r.vs = 1'b1;
    return r;
  endfunction

  function automatic pair_t sample();
    pair_t p;
    p.s = {10'(h_s), 10'(v_s), hs_s, vs_s, von_s, le_s, fe_s};
    p.d = {h_d, v_d, hs_d, vs_d, von_d, le_d, fe_d};
    return p;
  endfunction

  task automatic adv(input int k);
    int ht, vt;
    ht = (k == 0) ? 25 : 800;
    vt = (k == 0) ? 15 : 525;
    mh[k]++;
    if (mh[k] == ht) begin
      mh[k] = 0;
      mv[k]++;
      if (mv[k] == vt) mv[k] = 0;
    end
  endtask

  // One clock: update model at the edge, drive pix_en, push expectation.
  task automatic cyc(input logic pe);
    pair_t e;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      oreg[k] = lastc[k];
      if (last_pe) adv(k);
    end
    #1;
    pix_en  = pe;
    last_pe = pe;
    for (int k = 0; k < 2; k++)
      lastc[k] = model(k, mh[k], mv[k], pe);
    e.s = REG ? oreg[0] : lastc[0];
    e.d = REG ? oreg[1] : lastc[1];
    q.push_back(e);
    @(negedge clk);
  endtask

  // Assert reset asynchronously and push the expected reset view.
  task automatic apply_reset();
    pair_t e;
    pix_en  = 1'b0;
    rst_n   = 1'b0;
    last_pe = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mh[k]    = 0;
      mv[k]    = 0;
      lastc[k] = model(k, 0, 0, 1'b0);
      oreg[k]  = rstv();
    end
    e.s = REG ? rstv() : lastc[0];
    e.d = REG ? rstv() : lastc[1];
    q.push_back(e);
    #1;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    pair_t e, g;
    apply_reset();
    e = q.pop_front();
    g = sample();
    compared++;
    if (g !== e) begin
      mismatched++;
      $display("FAIL reset_async got=%h exp=%h", g, e);
    end
    repeat (3) @(posedge clk);
    #1;
    q.push_back(e);
    e = q.pop_front();
    g = sample();
    compared++;
    if (g !== e) begin
      mismatched++;
      $display("FAIL reset_hold got=%h exp=%h", g, e);
    end
    release_reset();
  endtask

  task automatic test_line_default();
    pair_t e, g;
    int    le_at, hs_lo;
    le_at = -1;
    hs_lo = 0;
    for (int i = 0; i < 810; i++) begin
      cyc(1'b1);
      e = q.pop_front();
      g = sample();
      compared++;
      if (g !== e) begin
        mismatched++;
        if (mismatched < 20)
          $display("FAIL line cyc=%0d got=%h exp=%h", i, g, e);
      end
      if (g.d.le && le_at < 0) le_at = i;
      if (!g.d.hs) hs_lo++;
    end
    compared++;
    if (le_at !== (REG ? 800 : 799)) begin
      mismatched++;
      $display("FAIL line_end_pos got=%0d exp=%0d",
               le_at, REG ? 800 : 799);
    end
    compared++;
    if (hs_lo !== 96) begin
      mismatched++;
      $display("FAIL hsync_width got=%0d exp=96", hs_lo);
    end
  endtask

  task automatic test_frame();
    pair_t e, g;
    int    fe_n, fe_first, fe_gap, vs_lo;
    apply_reset();
    void'(q.pop_front());
    release_reset();
    fe_n     = 0;
    fe_first = -1;
    fe_gap   = -1;
    vs_lo    = 0;
    for (int i = 0; i < 755; i++) begin
      cyc(1'b1);
      e = q.pop_front();
      g = sample();
      compared++;
      if (g !== e) begin
        mismatched++;
        if (mismatched < 20)
          $display("FAIL frame cyc=%0d got=%h exp=%h", i, g, e);
      end
      if (g.s.fe) begin
        if (fe_n == 1) fe_gap = i - fe_first;
        if (fe_n == 0) fe_first = i;
        fe_n++;
      end
      if (!g.s.vs) vs_lo++;
    end
    compared++;
    if (fe_n !== 2 || fe_gap !== 375) begin
      mismatched++;
      $display("FAIL frame_end got=%0d/%0d exp=2/375", fe_n, fe_gap);
    end
    compared++;
    if (vs_lo !== 100) begin
      mismatched++;
      $display("FAIL vsync_width got=%0d exp=100", vs_lo);
    end
  endtask

  task automatic test_sparse_en();
    pair_t e, g;
    int    le_n, le_prev, le_gap;
    apply_reset();
    void'(q.pop_front());
    release_reset();
    le_n    = 0;
    le_prev = -1;
    le_gap  = -1;
    for (int i = 0; i < 300; i++) begin
      cyc((i % 4) == 3);
      e = q.pop_front();
      g = sample();
      compared++;
      if (g !== e) begin
        mismatched++;
        if (mismatched < 20)
          $display("FAIL sparse cyc=%0d got=%h exp=%h", i, g, e);
      end
      if (g.s.le) begin
        if (le_n > 0) le_gap = i - le_prev;
        le_prev = i;
        le_n++;
      end
    end
    compared++;
    if (le_n !== 3 || le_gap !== 100) begin
      mismatched++;
      $display("FAIL line_period got=%0d/%0d exp=3/100", le_n, le_gap);
    end
  endtask

  task automatic test_async_reset();
    pair_t e, g;
    apply_reset();
    void'(q.pop_front());
    release_reset();
    for (int i = 0; i < 136; i++) begin
      cyc(1'b1);
      void'(q.pop_front());
    end
    e.s = REG ? model(0, 9, 5, 1'b1) : model(0, 10, 5, 1'b1);
    g = sample();
    compared++;
    if (g.s !== e.s) begin
      mismatched++;
      $display("FAIL pre_reset got=%h exp=%h", g.s, e.s);
    end
    apply_reset();
    e = q.pop_front();
    g = sample();
    compared++;
    if (g !== e) begin
      mismatched++;
      $display("FAIL reset_mid got=%h exp=%h", g, e);
    end
    release_reset();
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1);
      e = q.pop_front();
      g = sample();
      compared++;
      if (g !== e) begin
        mismatched++;
        if (mismatched < 20)
          $display("FAIL restart cyc=%0d got=%h exp=%h", i, g, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    pair_t e, g;
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)));
      e = q.pop_front();
      g = sample();
      compared++;
      if (g !== e) begin
        mismatched++;
        if (mismatched < 20)
          $display("FAIL random cyc=%0d got=%h exp=%h", i, g, e);
      end
    end
  endtask

  initial begin
    rst_n  = 1'b1;
    pix_en = 1'b0;
    #2;
    test_reset();
    test_line_default();
    test_frame();
    test_sparse_en();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator. A single block holds both the horizontal and vertical pixel counters and drives hsync, vsync, the active-video flag and line/frame strobes. It sits between the system clock domain and the pixel renderer/mole-drawing logic, and it replaces the separate fixed 640x480 counters. Timing is fully set by parameters; defaults give 640x480@60 (800x525 total).

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, sync asserted level (0 = active-low, per VGA 640x480)
CW, 10, counter width; must satisfy 2**CW > max(H_TOTAL, V_TOTAL)

Ports:
clk  input  1  system clock
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
pix_en  input  1  pixel-rate enable (e.g. 25 MHz tick from 100 MHz clk); counters advance only when high
h_count  output  CW  current pixel column, 0..H_TOTAL-1
v_count  output  CW  current line, 0..V_TOTAL-1
hsync  output  1  horizontal sync, level per SYNC_POL
vsync  output  1  vertical sync, level per SYNC_POL
video_on  output  1  high when h_count<H_ACTIVE and v_count<V_ACTIVE
line_end  output  1  one-clk strobe on the last pixel of each line
frame_end  output  1  one-clk strobe on the last pixel of each frame

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = the analogous sum (525).
- Reset (rst_n low, asynchronous): h_count=0, v_count=0. Outputs follow the counters at h=0,v=0: hsync/vsync inactive (!SYNC_POL), video_on=1, line_end=0, frame_end=0.
- pix_en=0: all state holds; strobes low.
- pix_en=1: h_count increments. At H_TOTAL-1 it wraps to 0 and v_count advances by 1. v_count wraps from V_TOTAL-1 to 0. Both wrap on the same edge at (H_TOTAL-1, V_TOTAL-1).
- hsync asserted when H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC (656..751). vsync asserted when V_ACTIVE+V_FP <= v_count < V_ACTIVE+V_FP+V_SYNC (490..491).
- line_end = pix_en && h_count==H_TOTAL-1. frame_end = line_end && v_count==V_TOTAL-1.
- Default build: sync, video_on and strobes are decoded combinationally from the registered counters (zero latency).
- Counter arithmetic is unsigned, width CW, with no overflow past TOTAL-1. Any out-of-range value (not reachable normally) is forced to wrap to 0 on the next pix_en.
- Reset asserted mid-frame: counters return to 0 immediately. Counting resumes on the first pix_en after release.

Optional Feature:
VGA_TIMING_OUT_REG_EN
- Defined: h_count, v_count, hsync, vsync, video_on, line_end and frame_end all pass through one output register stage, so the outputs lag the internal counters by exactly 1 clk and stay mutually aligned. On reset the stage holds counts 0, syncs inactive, video_on=0, strobes 0.
- Undefined: combinational decode as above, zero latency.

Decomposition:
- Package vga_timing_pkg holds the default 640x480 timing constants, the SYNC_POL encoding, and a function that computes TOTAL from active/porch/sync values.
- One sub-module, vga_axis_counter, is instantiated twice (h and v). It takes parameters ACTIVE/FP/SYNC/BP/CW and inputs clk, rst_n, step. It outputs count, wrap, sync_raw, active. The h instance steps on pix_en; the v instance steps on the h wrap.

Test Plan:
- Reset release, pix_en=1 constant: h_count reaches 799 on clk 800, line_end=1 that clk, then h_count=0 and v_count=1.
- Sync windows: hsync low exactly for h=656..751 (96 pixels). vsync low for v=490..491 only, with SYNC_POL=0.
- Full frame: frame_end pulses once every 420000 pix_en cycles. Both counters read 0 on the following enabled clk.
- pix_en every 4th clk: counters step only on enabled clks, and line period = 3200 clks.
- rst_n pulsed low asynchronously at h=300, v=200: counters read 0 before the next clk edge, and counting restarts on release.
- With VGA_TIMING_OUT_REG_EN defined: every output equals the undefined-build output delayed by 1 clk. video_on=0 during reset.
